// File: rtl/soc_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_irq_pkg
// Purpose  : Register map and sizing constants for the interrupt aggregator.
// Revision : 1.0 - initial release
// ============================================================================
package soc_irq_pkg;

  localparam int N_IRQ_MAX     = 16;
  localparam int VEC_VALID_BIT = 15;
  localparam int VEC_W         = $clog2(N_IRQ_MAX);

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_EDGE    = 3'd2;
  localparam logic [2:0] ADDR_VECTOR  = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;
  localparam logic [2:0] ADDR_CTRL    = 3'd5;

  typedef logic [15:0] reg_word_t;

endpackage : soc_irq_pkg
`default_nettype wire

// File: rtl/soc_irq_aggregator_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : soc_irq_prio_enc
// Purpose  : Combinational lowest-set-bit encoder (index plus valid).
// Revision : 1.0 - initial release
// ============================================================================
module soc_irq_prio_enc
  import soc_irq_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] i_req,
  output logic [VEC_W-1:0] o_index,
  output logic             o_valid
);

  // Scan from the top so the lowest set bit is the last one to land.
  always_comb begin
    o_index = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_index = VEC_W'(i);
      end
    end
  end

  assign o_valid = |i_req;

endmodule : soc_irq_prio_enc
`default_nettype wire

// File: rtl/soc_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : soc_irq_aggregator
// Purpose  : Avalon-MM interrupt aggregator with per-line mode, mask, sticky
//            pending bits and a lowest-index-wins vector.
// Revision : 1.0 - initial release
// ============================================================================
module soc_irq_aggregator
  import soc_irq_pkg::*;
#(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  output logic             irq,
  output logic [3:0]       irq_vector,
  output logic             irq_vector_valid
);

  logic [N_IRQ-1:0] r_irq_q;
  logic [N_IRQ-1:0] r_irq_q2;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_edge;
  logic             r_ctrl_en;
  reg_word_t        r_readdata;
  logic             r_irq;
  logic [3:0]       r_vec;
  logic             r_vec_valid;

  logic [N_IRQ-1:0] w_wdata;
  logic [N_IRQ-1:0] w_rise;
  logic [N_IRQ-1:0] w_active;
  logic [N_IRQ-1:0] w_mode_chg;
  logic [N_IRQ-1:0] w_pending_nxt;
  logic             w_wr_any;
  logic             w_wr_pending;
  logic             w_wr_mask;
  logic             w_wr_edge;
  logic             w_wr_ctrl;
  reg_word_t        w_read_mux;
  logic [VEC_W-1:0] w_enc_index;
  logic             w_enc_valid;
  logic             w_unused_wdata;

  assign w_wdata        = writedata[N_IRQ-1:0];
  assign w_unused_wdata = ^writedata;

  assign w_wr_any     = chipselect & ~write_n;
  assign w_wr_pending = w_wr_any & (address == ADDR_PENDING);
  assign w_wr_mask    = w_wr_any & (address == ADDR_MASK);
  assign w_wr_edge    = w_wr_any & (address == ADDR_EDGE);
  assign w_wr_ctrl    = w_wr_any & (address == ADDR_CTRL);

  assign w_rise     = r_irq_q & ~r_irq_q2;
  assign w_mode_chg = w_wr_edge ? (r_edge ^ w_wdata) : '0;
  assign w_active   = r_pending & r_mask & {N_IRQ{r_ctrl_en}};

  // Mode change clears first; in edge mode a rise beats a same-cycle W1C.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < N_IRQ; i++) begin
      if (w_mode_chg[i]) begin
        w_pending_nxt[i] = 1'b0;
      end else if (!r_edge[i]) begin
        w_pending_nxt[i] = r_irq_q[i];
      end else if (w_rise[i]) begin
        w_pending_nxt[i] = 1'b1;
      end else if (w_wr_pending && w_wdata[i]) begin
        w_pending_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_read_mux = '0;
    case (address)
      ADDR_PENDING: w_read_mux[N_IRQ-1:0] = r_pending;
      ADDR_MASK:    w_read_mux[N_IRQ-1:0] = r_mask;
      ADDR_EDGE:    w_read_mux[N_IRQ-1:0] = r_edge;
      ADDR_VECTOR: begin
        w_read_mux[VEC_VALID_BIT] = r_vec_valid;
        w_read_mux[3:0]           = r_vec;
      end
      ADDR_RAW:     w_read_mux[N_IRQ-1:0] = r_irq_q;
      ADDR_CTRL:    w_read_mux[0]         = r_ctrl_en;
      default:      w_read_mux            = '0;
    endcase
  end

  soc_irq_prio_enc #(
    .N_IRQ   (N_IRQ)
  ) u_prio_enc (
    .i_req   (w_active),
    .o_index (w_enc_index),
    .o_valid (w_enc_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_q     <= '0;
      r_irq_q2    <= '0;
      r_pending   <= '0;
      r_mask      <= '0;
      r_edge      <= '0;
      r_ctrl_en   <= 1'b0;
      r_readdata  <= '0;
      r_irq       <= 1'b0;
      r_vec       <= '0;
      r_vec_valid <= 1'b0;
    end else begin
      r_irq_q     <= irq_in;
      r_irq_q2    <= r_irq_q;
      r_pending   <= w_pending_nxt;
      if (w_wr_mask) r_mask    <= w_wdata;
      if (w_wr_edge) r_edge    <= w_wdata;
      if (w_wr_ctrl) r_ctrl_en <= writedata[0];
      // Updated unconditionally: the master samples one cycle after address.
      r_readdata  <= w_read_mux;
      r_irq       <= |w_active;
      r_vec       <= w_enc_valid ? 4'(w_enc_index) : 4'd0;
      r_vec_valid <= w_enc_valid;
    end
  end

  assign readdata         = r_readdata;
  assign irq              = r_irq;
  assign irq_vector       = r_vec;
  assign irq_vector_valid = r_vec_valid;

endmodule : soc_irq_aggregator
`default_nettype wire

// File: tb/tb_soc_irq_aggregator.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_irq_aggregator
// Purpose  : Directed stimulus with a read scoreboard for soc_irq_aggregator.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_soc_irq_aggregator;
  import soc_irq_pkg::*;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  irq_in;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [15:0]   writedata;
  logic [15:0]   readdata;
  logic          irq;
  logic [3:0]    irq_vector;
  logic          irq_vector_valid;

  always #5 clk = ~clk;

  soc_irq_aggregator #(.N_IRQ(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_in           (irq_in),
    .address          (address),
    .chipselect       (chipselect),
    .write_n          (write_n),
    .writedata        (writedata),
    .readdata         (readdata),
    .irq              (irq),
    .irq_vector       (irq_vector),
    .irq_vector_valid (irq_vector_valid)
  );

  typedef struct {
    logic [15:0] data;
    bit          chk_irq;
    logic        irq;
    logic [3:0]  vec;
    logic        vv;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;

  task automatic check(input string name, input int tag,
                       input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got 0x%04h expected 0x%04h", name, tag, act, exp);
    end
  endtask

  // Monitor: a read sampled at a rising edge is compared at the next falling edge.
  initial begin : mon
    forever begin
      logic was_rd;
      exp_t e;
      @(posedge clk);
      was_rd = chipselect & write_n;
      @(negedge clk);
      if (was_rd) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: read completed with no expected entry");
        end else begin
          e = q.pop_front();
          check("readdata", e.tag, readdata, e.data);
          if (e.chk_irq) begin
            check("irq", e.tag, {15'd0, irq}, {15'd0, e.irq});
            check("irq_vector", e.tag, {12'd0, irq_vector}, {12'd0, e.vec});
            check("irq_vector_valid", e.tag, {15'd0, irq_vector_valid}, {15'd0, e.vv});
          end
        end
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] d, input bit ci,
                    input logic ei, input logic [3:0] ev, input logic evv);
    exp_t e;
    e.data = d; e.chk_irq = ci; e.irq = ei; e.vec = ev; e.vv = evv; e.tag = tag_n;
    tag_n++;
    q.push_back(e);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : stim
    reset = 1'b1; irq_in = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    idle(2);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, 1, 1'b0, 4'd0, 1'b0);

    // Line 0, level mode
    wr(ADDR_CTRL, 16'h0001);
    wr(ADDR_MASK, 16'h0001);
    irq_in = 8'h01;
    idle(3);
    rd(ADDR_VECTOR,  16'h8000, 1, 1'b1, 4'd0, 1'b1);
    rd(ADDR_PENDING, 16'h0001, 1, 1'b1, 4'd0, 1'b1);
    rd(ADDR_RAW,     16'h0001, 0, 1'b0, 4'd0, 1'b0);
    irq_in = 8'h00;
    idle(3);
    rd(ADDR_VECTOR,  16'h0000, 1, 1'b0, 4'd0, 1'b0);

    // Line 3, edge mode, sticky
    wr(ADDR_MASK, 16'h0008);
    wr(ADDR_EDGE, 16'h0008);
    irq_in = 8'h08;
    idle(1);
    irq_in = 8'h00;
    idle(4);
    rd(ADDR_PENDING, 16'h0008, 1, 1'b1, 4'd3, 1'b1);
    rd(ADDR_VECTOR,  16'h8003, 1, 1'b1, 4'd3, 1'b1);
    rd(ADDR_RAW,     16'h0000, 0, 1'b0, 4'd0, 1'b0);
    wr(ADDR_PENDING, 16'h0008);
    rd(ADDR_PENDING, 16'h0000, 1, 1'b0, 4'd0, 1'b0);

    // Rise and W1C land on the same edge: the set must win
    irq_in = 8'h08;
    idle(1);
    irq_in = 8'h00;
    wr(ADDR_PENDING, 16'h0008);
    idle(2);
    rd(ADDR_PENDING, 16'h0008, 1, 1'b1, 4'd3, 1'b1);
    wr(ADDR_PENDING, 16'h0008);
    idle(1);

    // Lines 2 and 5: priority, masking, global disable
    wr(ADDR_EDGE, 16'h0024);
    wr(ADDR_MASK, 16'h0024);
    irq_in = 8'h24;
    idle(1);
    irq_in = 8'h00;
    idle(4);
    rd(ADDR_VECTOR,  16'h8002, 1, 1'b1, 4'd2, 1'b1);
    rd(ADDR_PENDING, 16'h0024, 1, 1'b1, 4'd2, 1'b1);
    wr(ADDR_MASK, 16'h0020);
    rd(ADDR_VECTOR,  16'h8002, 1, 1'b1, 4'd5, 1'b1);
    rd(ADDR_VECTOR,  16'h8005, 1, 1'b1, 4'd5, 1'b1);
    wr(ADDR_CTRL, 16'h0000);
    rd(ADDR_PENDING, 16'h0024, 1, 1'b0, 4'd0, 1'b0);

    // Fill all lines, then reset mid-operation with line 0 held high
    wr(ADDR_EDGE, 16'h00FF);
    wr(ADDR_MASK, 16'h00FF);
    wr(ADDR_CTRL, 16'h0001);
    irq_in = 8'hFF;
    idle(1);
    irq_in = 8'h01;
    idle(4);
    rd(ADDR_PENDING, 16'h00FF, 1, 1'b1, 4'd0, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    rd(ADDR_PENDING, 16'h0000, 1, 1'b0, 4'd0, 1'b0);
    idle(2);
    rd(ADDR_PENDING, 16'h0001, 1, 1'b0, 4'd0, 1'b0);
    rd(ADDR_MASK,    16'h0000, 0, 1'b0, 4'd0, 1'b0);
    rd(ADDR_EDGE,    16'h0000, 0, 1'b0, 4'd0, 1'b0);
    rd(ADDR_CTRL,    16'h0000, 0, 1'b0, 4'd0, 1'b0);
    rd(ADDR_RAW,     16'h0001, 0, 1'b0, 4'd0, 1'b0);

    // Bits above N_IRQ and unused addresses
    wr(ADDR_MASK, 16'hFFFF);
    rd(ADDR_MASK,    16'h00FF, 1, 1'b0, 4'd0, 1'b0);
    wr(ADDR_CTRL, 16'hFFFF);
    rd(ADDR_CTRL,    16'h0001, 0, 1'b0, 4'd0, 1'b0);
    idle(2);
    rd(ADDR_VECTOR,  16'h8000, 1, 1'b1, 4'd0, 1'b1);
    wr(3'd6, 16'hFFFF);
    rd(3'd6,         16'h0000, 0, 1'b0, 4'd0, 1'b0);
    wr(3'd7, 16'hFFFF);
    rd(3'd7,         16'h0000, 1, 1'b1, 4'd0, 1'b1);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d reads still outstanding, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_soc_irq_aggregator
`default_nettype wire
